jesd_rx_ramp_checker: RTL and testbench

- Receive-side data checker for the ADRV9009 JESD204 loopback benches.
- Consumes the flattened sample bus from the RX transport-layer core, M channels by S samples per beat.
- Locks onto the incrementing ramp from the TX exerciser pattern generator, then counts every mismatched sample.
- Exposes lock and error status so test programs can pass or fail a link without parsing data.

---
 rtl/jesd_rx_ramp_checker_pkg.sv | 27 ++
 rtl/jesd_ramp_beat_compare.sv | 53 +++++
 rtl/jesd_rx_ramp_checker.sv | 199 +++++++++++++++++++
 tb/tb_jesd_rx_ramp_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/jesd_rx_ramp_checker_pkg.sv
// Shared types and ramp arithmetic for the JESD204 RX ramp checker.
package jesd_rx_ramp_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_CHECK   = 2'd2
   } state_e;

   // Ramp value carried by slot (i,j) of a beat whose slot (0,0) holds base.
   // The caller truncates to NP bits, which makes the sum modulo 2^NP.
   function automatic logic [31:0] slot_expected(input logic [31:0] base,
                                                 input logic [31:0] i,
                                                 input logic [31:0] j,
                                                 input logic [31:0] num_ch);
      return base + num_ch * j + i;
   endfunction

   // 32-bit add that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                             input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? '1 : sum[31:0];
   endfunction

endpackage

// File: rtl/jesd_ramp_beat_compare.sv
// Combinational compare of one sample beat against a ramp base, plus a
// self-consistency test of the beat against its own slot (0,0).
module jesd_ramp_beat_compare
   import jesd_rx_ramp_checker_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int SAMPLES_PER_CH = 2,
   parameter int NP             = 16,
   localparam int NSLOT         = NUM_CH * SAMPLES_PER_CH,
   localparam int CW            = $clog2(NSLOT + 1),
   localparam int IW            = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
   input  logic [NP-1:0]       base_i,
   input  logic [NSLOT*NP-1:0] data_i,
   output logic [NSLOT-1:0]    mismatch_o,
   output logic [CW-1:0]       mism_count_o,
   output logic [IW-1:0]       first_idx_o,
   output logic                self_consistent_o,
   output logic                all_zero_o
);

   logic [NP-1:0]    slot00;
   logic [NSLOT-1:0] consistent;

   assign slot00     = data_i[NP-1:0];
   assign all_zero_o = (data_i == '0);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      for (genvar gj = 0; gj < SAMPLES_PER_CH; gj++) begin : g_smp
         localparam int K = SAMPLES_PER_CH * gi + gj;
         logic [NP-1:0] slot;
         assign slot          = data_i[NP*K +: NP];
         assign mismatch_o[K] = slot != NP'(slot_expected(32'(base_i), 32'(gi), 32'(gj), 32'(NUM_CH)));
         assign consistent[K] = slot == NP'(slot_expected(32'(slot00), 32'(gi), 32'(gj), 32'(NUM_CH)));
      end
   end

   assign self_consistent_o = &consistent;

   // Popcount of mismatches; scanning downward leaves the lowest index in first_idx_o.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      mism_count_o = '0;
      first_idx_o  = '0;
      for (int k = NSLOT - 1; k >= 0; k--) begin
         if (mismatch_o[k]) begin
            mism_count_o = mism_count_o + CW'(1);
            first_idx_o  = IW'(k);
         end
      end
   end

endmodule

// File: rtl/jesd_rx_ramp_checker.sv
// JESD204 RX ramp checker: acquires lock on the TX exerciser ramp, then
// counts mismatched samples and captures the first failure.
module jesd_rx_ramp_checker
   import jesd_rx_ramp_checker_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int SAMPLES_PER_CH = 2,
   parameter int NP             = 16,
   parameter int LOCK_BEATS     = 4,
   parameter int RESYNC_BEATS   = 8
) (
   input  logic                                clk,
   input  logic                                resetn,
   input  logic                                enable,
   input  logic                                clear,
   input  logic                                s_valid,
   input  logic [NUM_CH*SAMPLES_PER_CH*NP-1:0] s_data,
   output logic                                locked,
   output logic                                error_flag,
   output logic [31:0]                         error_count,
   output logic [31:0]                         beat_count,
   output logic [NP-1:0]                       first_err_expected,
   output logic [NP-1:0]                       first_err_received,
   output logic [1:0]                          state
);

   localparam int NSLOT = NUM_CH * SAMPLES_PER_CH;
   localparam int CW    = $clog2(NSLOT + 1);
   localparam int IW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int RW    = $clog2(LOCK_BEATS + 1);
   localparam int BW    = $clog2(RESYNC_BEATS + 1);
   localparam logic [NP-1:0] STEP = NP'(NSLOT);

   state_e        state_q, state_d;
   logic          locked_q, locked_d;
   logic [NP-1:0] base_q, base_d;
   logic [RW-1:0] run_q, run_d, run_n;
   logic [BW-1:0] bad_q, bad_d, bad_n;
   logic [31:0]   err_cnt_q, err_cnt_d;
   logic [31:0]   beat_cnt_q, beat_cnt_d;
   logic          flag_q, flag_d;
   logic [NP-1:0] fe_q, fe_d, fr_q, fr_d;

   logic [NSLOT-1:0] mismatch;
   logic [CW-1:0]    mism_count;
   logic [IW-1:0]    first_idx;
   logic             self_cons;
   logic             all_zero;
   logic             any_mism;
   logic [NP-1:0]    slot00;
   logic [NP-1:0]    first_exp;
   logic [NP-1:0]    first_rcv;
   logic [31:0]      fidx32;

   // base_q is the predicted base in ACQUIRE and the expected base in CHECK.
   jesd_ramp_beat_compare #(
      .NUM_CH         (NUM_CH),
      .SAMPLES_PER_CH (SAMPLES_PER_CH),
      .NP             (NP)
   ) u_cmp (
      .base_i            (base_q),
      .data_i            (s_data),
      .mismatch_o        (mismatch),
      .mism_count_o      (mism_count),
      .first_idx_o       (first_idx),
      .self_consistent_o (self_cons),
      .all_zero_o        (all_zero)
   );

   assign any_mism  = |mismatch;
   assign slot00    = s_data[NP-1:0];
   assign fidx32    = 32'(first_idx);
   assign first_exp = NP'(slot_expected(32'(base_q), fidx32 / 32'(SAMPLES_PER_CH),
                                        fidx32 % 32'(SAMPLES_PER_CH), 32'(NUM_CH)));
   assign first_rcv = s_data[NP*first_idx +: NP];

   // Next-state: clear zeroes the counters first, then the current beat adds its share.
   always_comb begin
      state_d    = state_q;
      locked_d   = locked_q;
      base_d     = base_q;
      run_d      = run_q;
      bad_d      = bad_q;
      err_cnt_d  = err_cnt_q;
      beat_cnt_d = beat_cnt_q;
      flag_d     = flag_q;
      fe_d       = fe_q;
      fr_d       = fr_q;
      run_n      = run_q;
      bad_n      = bad_q;

      if (clear) begin
         err_cnt_d  = '0;
         beat_cnt_d = '0;
         flag_d     = 1'b0;
         fe_d       = '0;
         fr_d       = '0;
      end

      if (!enable) begin
         // Any beat in this cycle is dropped; a later enable starts a fresh acquisition.
         state_d  = ST_IDLE;
         locked_d = 1'b0;
         run_d    = '0;
         bad_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ACQUIRE;
            end

            ST_ACQUIRE: begin
               // All-zero beats mean the generator is off; they neither extend nor break the run.
               if (s_valid && !all_zero) begin
                  if (self_cons) begin
                     run_n  = (run_q == '0 || slot00 == base_q) ? run_q + RW'(1) : RW'(1);
                     base_d = slot00 + STEP;
                  end else begin
                     run_n = '0;
                  end
                  if (run_n == RW'(LOCK_BEATS)) begin
                     state_d  = ST_CHECK;
                     locked_d = 1'b1;
                     run_d    = '0;
                     bad_d    = '0;
                  end else begin
                     run_d = run_n;
                  end
               end
            end

            ST_CHECK: begin
               if (s_valid) begin
                  // The base advances even on a corrupt beat so only its bad slots are charged.
                  base_d     = base_q + STEP;
                  beat_cnt_d = sat_add32(beat_cnt_d, 32'd1);
                  err_cnt_d  = sat_add32(err_cnt_d, 32'(mism_count));
                  if (any_mism && !flag_d) begin
                     flag_d = 1'b1;
                     fe_d   = first_exp;
                     fr_d   = first_rcv;
                  end
                  bad_n = any_mism ? bad_q + BW'(1) : '0;
                  if (bad_n == BW'(RESYNC_BEATS)) begin
                     state_d  = ST_ACQUIRE;
                     locked_d = 1'b0;
                     run_d    = '0;
                     bad_d    = '0;
                  end else begin
                     bad_d = bad_n;
                  end
               end
            end

            default: begin
               state_d  = ST_IDLE;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   // State and status registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q    <= ST_IDLE;
         locked_q   <= 1'b0;
         base_q     <= '0;
         run_q      <= '0;
         bad_q      <= '0;
         err_cnt_q  <= '0;
         beat_cnt_q <= '0;
         flag_q     <= 1'b0;
         fe_q       <= '0;
         fr_q       <= '0;
      end else begin
         state_q    <= state_d;
         locked_q   <= locked_d;
         base_q     <= base_d;
         run_q      <= run_d;
         bad_q      <= bad_d;
         err_cnt_q  <= err_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         flag_q     <= flag_d;
         fe_q       <= fe_d;
         fr_q       <= fr_d;
      end
   end

   assign locked             = locked_q;
   assign error_flag         = flag_q;
   assign error_count        = err_cnt_q;
   assign beat_count         = beat_cnt_q;
   assign first_err_expected = fe_q;
   assign first_err_received = fr_q;
   assign state              = state_q;

endmodule

// File: tb/tb_jesd_rx_ramp_checker.sv
// Table-driven bench for jesd_rx_ramp_checker with NUM_CH=4, S=2, NP=16.
module tb_jesd_rx_ramp_checker;

   localparam int NUM_CH = 4;
   localparam int S      = 2;
   localparam int NP     = 16;
   localparam int DW     = NUM_CH * S * NP;

   logic          clk = 1'b0;
   logic          resetn, enable, clear, s_valid;
   logic [DW-1:0] s_data;
   logic          locked, error_flag;
   logic [31:0]   error_count, beat_count;
   logic [NP-1:0] first_err_expected, first_err_received;
   logic [1:0]    state;

   jesd_rx_ramp_checker #(
      .NUM_CH         (NUM_CH),
      .SAMPLES_PER_CH (S),
      .NP             (NP),
      .LOCK_BEATS     (4),
      .RESYNC_BEATS   (8)
   ) dut (
      .clk                (clk),
      .resetn             (resetn),
      .enable             (enable),
      .clear              (clear),
      .s_valid            (s_valid),
      .s_data             (s_data),
      .locked             (locked),
      .error_flag         (error_flag),
      .error_count        (error_count),
      .beat_count         (beat_count),
      .first_err_expected (first_err_expected),
      .first_err_received (first_err_received),
      .state              (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en, clr, vld, zero;
      logic [15:0] base;
      logic [7:0]  bad;
      logic [1:0]  st;
      logic        lk;
      int unsigned err, beats;
      logic        flag;
      logic [15:0] fe, fr;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] efe = '0, efr = '0;
   int          n_vec = 0;
   int          n_bad = 0;

   // Ramp beat from the bench's own model; bad[k] flips bit 0 of slot k.
   function automatic logic [DW-1:0] make_beat(input logic [15:0] base, input logic [7:0] bad,
                                               input logic zero);
      logic [DW-1:0] d = '0;
      logic [15:0]   v;
      if (!zero) begin
         for (int i = 0; i < NUM_CH; i++) begin
            for (int j = 0; j < S; j++) begin
               v = base + 16'(NUM_CH * j + i);
               if (bad[S*i+j]) v = v ^ 16'h0001;
               d[NP*(S*i+j) +: NP] = v;
            end
         end
      end
      return d;
   endfunction

   function automatic void add(input logic en, clr, vld, zero, input logic [15:0] base,
                               input logic [7:0] bad, input logic [1:0] st, input logic lk,
                               input int unsigned err, beats, input logic flag);
      vec_t v;
      v.en = en; v.clr = clr; v.vld = vld; v.zero = zero; v.base = base; v.bad = bad;
      v.st = st; v.lk = lk; v.err = err; v.beats = beats; v.flag = flag;
      v.fe = efe; v.fr = efr;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after an edge, then wait past the next edge.
   task automatic step(input logic en, clr, vld, input logic [DW-1:0] data);
      enable = en; clear = clr; s_valid = vld; s_data = data;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_core(input string name, input logic [1:0] st, input logic lk,
                              input int unsigned err, beats);
      check({name, " state"}, 32'(state), 32'(st));
      check({name, " locked"}, 32'(locked), 32'(lk));
      check({name, " error_count"}, error_count, err);
      check({name, " beat_count"}, beat_count, beats);
   endtask

   initial begin
      resetn = 1'b0; enable = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (2) @(posedge clk);
      #1;
      expect_core("reset", 2'd0, 1'b0, 0, 0);
      check("reset error_flag", 32'(error_flag), 32'd0);
      check("reset first_exp", 32'(first_err_expected), 32'd0);
      check("reset first_rcv", 32'(first_err_received), 32'd0);
      resetn = 1'b1;

      // Acquire on bases 0..24, lock, first counted beat at 32.
      add(1,0,0,0, 16'h0000, 8'h00, 1,0, 0,0, 0);
      add(1,0,1,0, 16'h0000, 8'h00, 1,0, 0,0, 0);
      add(1,0,1,0, 16'h0008, 8'h00, 1,0, 0,0, 0);
      add(1,0,1,0, 16'h0010, 8'h00, 1,0, 0,0, 0);
      add(1,0,1,0, 16'h0018, 8'h00, 2,1, 0,0, 0);
      add(1,0,1,0, 16'h0020, 8'h00, 2,1, 0,1, 0);
      // Single bad slot (2,1) at base 48: expected 0x36, received 0x37.
      add(1,0,1,0, 16'h0028, 8'h00, 2,1, 0,2, 0);
      efe = 16'h0036; efr = 16'h0037;
      add(1,0,1,0, 16'h0030, 8'h20, 2,1, 1,3, 1);
      add(1,0,1,0, 16'h0038, 8'h00, 2,1, 1,4, 1);
      add(1,0,0,0, 16'h0000, 8'h00, 2,1, 1,4, 1);
      // Eight beats with two bad slots each: lock drops after the eighth.
      for (int k = 1; k <= 8; k++)
         add(1,0,1,0, 16'(56 + 8*k), 8'h81, (k == 8) ? 2'd1 : 2'd2, k != 8,
             1 + 2*k, 4 + k, 1);
      for (int k = 0; k < 4; k++)
         add(1,0,1,0, 16'(128 + 8*k), 8'h00, (k == 3) ? 2'd2 : 2'd1, k == 3, 17, 12, 1);
      add(1,0,1,0, 16'h00A0, 8'h00, 2,1, 17,13, 1);
      // Disable, re-enable, ten generator-off beats, then gapped ramp from 0x40.
      add(0,0,0,0, 16'h0000, 8'h00, 0,0, 17,13, 1);
      add(1,0,0,0, 16'h0000, 8'h00, 1,0, 17,13, 1);
      for (int k = 0; k < 10; k++)
         add(1,0,1,1, 16'h0000, 8'h00, 1,0, 17,13, 1);
      add(1,0,1,0, 16'h0040, 8'h00, 1,0, 17,13, 1);
      add(1,0,0,0, 16'h0000, 8'h00, 1,0, 17,13, 1);
      add(1,0,1,0, 16'h0048, 8'h00, 1,0, 17,13, 1);
      add(1,0,0,0, 16'h0000, 8'h00, 1,0, 17,13, 1);
      add(1,0,1,0, 16'h0050, 8'h00, 1,0, 17,13, 1);
      add(1,0,1,0, 16'h0058, 8'h00, 2,1, 17,13, 1);
      add(1,0,1,0, 16'h0060, 8'h00, 2,1, 17,14, 1);
      // Wrap: lock at 0xFFDC..0xFFF4, then 0xFFFC wraps inside the beat.
      add(0,0,0,0, 16'h0000, 8'h00, 0,0, 17,14, 1);
      add(1,0,0,0, 16'h0000, 8'h00, 1,0, 17,14, 1);
      add(1,0,1,0, 16'hFFDC, 8'h00, 1,0, 17,14, 1);
      add(1,0,1,0, 16'hFFE4, 8'h00, 1,0, 17,14, 1);
      add(1,0,1,0, 16'hFFEC, 8'h00, 1,0, 17,14, 1);
      add(1,0,1,0, 16'hFFF4, 8'h00, 2,1, 17,14, 1);
      add(1,0,1,0, 16'hFFFC, 8'h00, 2,1, 17,15, 1);
      add(1,0,1,0, 16'h0004, 8'h00, 2,1, 17,16, 1);
      add(1,0,1,0, 16'h000C, 8'h00, 2,1, 17,17, 1);
      // Clear alone, then clear together with a bad beat (slot (0,1): 0x18 -> 0x19).
      efe = 16'h0000; efr = 16'h0000;
      add(1,1,0,0, 16'h0000, 8'h00, 2,1, 0,0, 0);
      efe = 16'h0018; efr = 16'h0019;
      add(1,1,1,0, 16'h0014, 8'h02, 2,1, 1,1, 1);
      add(1,0,1,0, 16'h001C, 8'h00, 2,1, 1,2, 1);
      // Enable falls with a fully corrupt beat: beat dropped, counters held.
      add(0,0,1,0, 16'h0024, 8'hFF, 0,0, 1,2, 1);

      foreach (vecs[n]) begin
         step(vecs[n].en, vecs[n].clr, vecs[n].vld,
              make_beat(vecs[n].base, vecs[n].bad, vecs[n].zero));
         expect_core($sformatf("v%0d", n), vecs[n].st, vecs[n].lk, vecs[n].err, vecs[n].beats);
         check($sformatf("v%0d error_flag", n), 32'(error_flag), 32'(vecs[n].flag));
         check($sformatf("v%0d first_exp", n), 32'(first_err_expected), 32'(vecs[n].fe));
         check($sformatf("v%0d first_rcv", n), 32'(first_err_received), 32'(vecs[n].fr));
      end

      // Discontinuous but self-consistent beat restarts the run at 1.
      step(1, 0, 0, '0);
      check("restart idle->acq", 32'(state), 32'd1);
      step(1, 0, 1, make_beat(16'h0200, 8'h00, 1'b0));
      step(1, 0, 1, make_beat(16'h0208, 8'h00, 1'b0));
      step(1, 0, 1, make_beat(16'h0300, 8'h00, 1'b0));
      step(1, 0, 1, make_beat(16'h0308, 8'h00, 1'b0));
      check("restart run2", 32'(state), 32'd1);
      step(1, 0, 1, make_beat(16'h0310, 8'h00, 1'b0));
      check("restart run3", 32'(state), 32'd1);
      step(1, 0, 1, make_beat(16'h0318, 8'h00, 1'b0));
      expect_core("restart lock", 2'd2, 1'b1, 1, 2);
      step(1, 0, 1, make_beat(16'h0320, 8'h01, 1'b0));
      expect_core("pre-reset", 2'd2, 1'b1, 2, 3);

      // Reset mid-CHECK with a valid beat present.
      resetn = 1'b0;
      step(1, 0, 1, make_beat(16'h0328, 8'h00, 1'b0));
      expect_core("midreset", 2'd0, 1'b0, 0, 0);
      check("midreset error_flag", 32'(error_flag), 32'd0);
      check("midreset first_exp", 32'(first_err_expected), 32'd0);
      check("midreset first_rcv", 32'(first_err_received), 32'd0);
      resetn = 1'b1;
      step(1, 0, 0, '0);
      check("post-reset acq", 32'(state), 32'd1);
      step(1, 0, 1, make_beat(16'h0330, 8'h00, 1'b0));
      step(1, 0, 1, make_beat(16'h0338, 8'h00, 1'b0));
      step(1, 0, 1, make_beat(16'h0340, 8'h00, 1'b0));
      expect_core("no residual lock", 2'd1, 1'b0, 0, 0);
      step(1, 0, 1, make_beat(16'h0348, 8'h00, 1'b0));
      expect_core("relock after reset", 2'd2, 1'b1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
